branch_tracker: RTL and testbench
=================================

Name: branch_tracker

Overview:
- In-order tracker for conditional branches in flight between fetch/issue and commit.
- Records each branch's PC, predicted direction and alternate PC. Accepts out-of-order resolutions from the ALU, and retires branches in program order.
- On retirement, drives the predictor's update interface (updateValid/updateInstr/taken). On a mispredict, raises a one-cycle flush carrying the correct PC.
- Also counts retired and mispredicted branches for performance readout.

Parameters:
- DEPTH_WIDTH, 3, log2 of entry count (DEPTH = 2**DEPTH_WIDTH = 8).
- ADDR_WIDTH, 32, instruction address width.

Ports:
- clockIn  input  1  clock, rising edge
- resetIn  input  1  asynchronous active-low reset (0 = reset)
- readyIn  input  1  global enable; 0 freezes state
- allocValid  input  1  new conditional branch enters tracker
- allocAddr  input  ADDR_WIDTH  branch instruction address
- allocPredTaken  input  1  direction predicted at fetch
- allocAltPC  input  ADDR_WIDTH  PC of the non-predicted path
- allocTag  output  DEPTH_WIDTH  tag assigned to this cycle's alloc (= tail pointer, combinational)
- full  output  1  count == DEPTH (combinational)
- empty  output  1  count == 0 (combinational)
- resolveValid  input  1  ALU resolution strobe
- resolveTag  input  DEPTH_WIDTH  tag being resolved
- resolveTaken  input  1  actual direction
- updateValid  output  1  registered one-cycle predictor update strobe
- updateInstr  output  ADDR_WIDTH  retired branch address
- taken  output  1  retired branch actual direction
- flushOut  output  1  registered one-cycle mispredict flush
- flushPC  output  ADDR_WIDTH  redirect target (entry's allocAltPC)
- branchCount  output  32  retired branches
- mispredictCount  output  32  retired mispredicted branches

Behaviour:
- Reset (resetIn=0, asynchronous):
  - head, tail and count are 0; all entry valid/resolved bits are 0.
  - updateValid, taken, flushOut, updateInstr, flushPC, branchCount and mispredictCount are all 0.
- readyIn=0 at an edge:
  - updateValid and flushOut are cleared.
  - No other state changes; alloc and resolve inputs are ignored.
- Entry fields: valid, resolved, addr, predTaken, actualTaken, altPC.
- Alloc (readyIn=1, allocValid=1, full=0):
  - Entry[tail] is written with valid=1, resolved=0.
  - tail increments modulo DEPTH.
  - allocValid while full=1 is dropped, even if a pop occurs in the same cycle.
- Resolve (readyIn=1, resolveValid=1):
  - If entry[resolveTag] is valid and not yet resolved: set resolved=1 and actualTaken=resolveTaken.
  - Otherwise (invalid or already resolved) the resolve is ignored.
- Retire: evaluated each edge with readyIn=1, using registered state only.
  - Condition: entry[head] valid and resolved.
  - Then: updateValid<=1, updateInstr<=addr, taken<=actualTaken, branchCount+=1.
  - Entry[head] is cleared and head increments.
  - If no retire occurs, updateValid<=0.
- Latency: resolve at edge E, head entry → updateValid high in the cycle after edge E+1. At most one retire per cycle.
- Mispredict (retiring entry has actualTaken != predTaken):
  - flushOut<=1, flushPC<=altPC, mispredictCount+=1.
  - In the same edge, all entries are invalidated and head=tail=count=0.
  - A same-cycle alloc or resolve is discarded; flush has priority.
  - flushOut is a single-cycle pulse.
- Count arithmetic: count is DEPTH_WIDTH+1 bits.
  - Alloc+retire in the same cycle: count unchanged.
  - Wrap of head/tail is natural modulo DEPTH.
- Counters: 32-bit, wrap silently at 2**32.
- Reset asserted mid-operation: all in-flight entries are lost and no update is emitted.

Decomposition:
- Shared package holds:
  - DEPTH_WIDTH and ADDR_WIDTH defaults.
  - Entry field bit positions, if entries are packed.
  - The 32-bit counter width constant.
- One natural sub-module, branch_tracker_fifo: entry storage plus head/tail/count, with alloc, pop and clear ports.
- The top level holds retire/flush logic and the counters.

Test Plan:
- Reset, then alloc addr=0x1000 pred=1 alt=0x1004; resolve tag0 taken=1 → one cycle later updateValid=1, updateInstr=0x1000, taken=1, flushOut=0, branchCount=1.
- Alloc 0x2000 (tag0) and 0x2010 (tag1); resolve tag1 first, then tag0 → no update until tag0 resolves; then updates are emitted for 0x2000 and 0x2010 on consecutive cycles, in order.
- Alloc 0x3000 pred=0 alt=0x3100, then 0x3004; resolve tag0 taken=1 → flushOut=1, flushPC=0x3100, mispredictCount=1, empty=1 next cycle; the 0x3004 entry is never updated.
- Alloc 8 branches → full=1; a 9th alloc is dropped (allocTag unchanged); retire one → full=0 and the next alloc gets tag0 (wrap).
- Hold readyIn=0 for 3 cycles with a resolved head → no updateValid; updateValid asserts after readyIn returns to 1.
- Assert resetIn=0 asynchronously with 4 entries pending and updateValid=1 → all outputs 0 immediately; count=0 after release.

Source files
------------

// File: rtl/branch_tracker_pkg.sv
// -----------------------------------------------------------------------------
// branch_tracker_pkg
//
// Shared definitions for the in-order conditional-branch tracker:
//   - default tracker geometry (entry count log2, address width)
//   - width of the retired / mispredicted performance counters
//   - packed per-entry control record
//   - mispredict helper used at retirement
// -----------------------------------------------------------------------------
package branch_tracker_pkg;

    localparam int BT_DEPTH_WIDTH = 3;
    localparam int BT_ADDR_WIDTH  = 32;
    localparam int BT_CNT_WIDTH   = 32;

    // Per-entry control bits. The address fields live in separate arrays
    // because their width is a module parameter.
    typedef struct packed {
        logic valid;
        logic resolved;
        logic pred_taken;
        logic actual_taken;
    } entry_ctrl_t;

    // Bit positions of the fields when an entry_ctrl_t is viewed as a vector.
    localparam int BT_BIT_VALID        = 3;
    localparam int BT_BIT_RESOLVED     = 2;
    localparam int BT_BIT_PRED_TAKEN   = 1;
    localparam int BT_BIT_ACTUAL_TAKEN = 0;

    function automatic logic is_mispredict(input logic pred_taken,
                                           input logic actual_taken);
        return pred_taken != actual_taken;
    endfunction

endpackage

// File: rtl/branch_tracker_fifo.sv
// -----------------------------------------------------------------------------
// branch_tracker_fifo
//
// Circular entry store for in-flight branches with head/tail/count tracking.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   alloc           write a new entry at the tail (dropped when full or clear)
//   alloc_addr      branch instruction address
//   alloc_pred      predicted direction
//   alloc_alt       PC of the non-predicted path
//   resolve         resolution strobe (ignored for invalid/resolved entries)
//   resolve_tag     entry being resolved
//   resolve_taken   actual direction
//   pop             retire the head entry (only asserted when head_ready)
//   clear           invalidate every entry and zero the pointers; wins over
//                   any alloc/resolve/pop in the same cycle
//   tail_tag        tag the next alloc will receive
//   full, empty     occupancy flags
//   head_ready      head entry is valid and resolved
//   head_addr/head_alt/head_pred/head_actual  head entry fields
// -----------------------------------------------------------------------------
module branch_tracker_fifo
    import branch_tracker_pkg::*;
#(
    parameter int DEPTH_WIDTH = BT_DEPTH_WIDTH,
    parameter int ADDR_WIDTH  = BT_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alloc,
    input  logic [ADDR_WIDTH-1:0]  alloc_addr,
    input  logic                   alloc_pred,
    input  logic [ADDR_WIDTH-1:0]  alloc_alt,
    input  logic                   resolve,
    input  logic [DEPTH_WIDTH-1:0] resolve_tag,
    input  logic                   resolve_taken,
    input  logic                   pop,
    input  logic                   clear,
    output logic [DEPTH_WIDTH-1:0] tail_tag,
    output logic                   full,
    output logic                   empty,
    output logic                   head_ready,
    output logic [ADDR_WIDTH-1:0]  head_addr,
    output logic [ADDR_WIDTH-1:0]  head_alt,
    output logic                   head_pred,
    output logic                   head_actual
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0]   FULL_COUNT = (DEPTH_WIDTH + 1)'(DEPTH);
    localparam logic [DEPTH_WIDTH:0]   COUNT_ONE  = (DEPTH_WIDTH + 1)'(1);
    localparam logic [DEPTH_WIDTH-1:0] PTR_ONE    = DEPTH_WIDTH'(1);

    entry_ctrl_t             ctrl     [DEPTH];
    logic [ADDR_WIDTH-1:0]   addr_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   alt_mem  [DEPTH];

    logic [DEPTH_WIDTH-1:0]  head;
    logic [DEPTH_WIDTH-1:0]  tail;
    logic [DEPTH_WIDTH:0]    count;
    logic [DEPTH_WIDTH:0]    count_next;

    logic                    alloc_ok;
    logic                    resolve_ok;
    entry_ctrl_t             resolve_entry;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign tail_tag = tail;

    // A full tracker drops the alloc even when the head retires in the same
    // cycle: the decision uses the registered count only.
    assign alloc_ok      = alloc && !full && !clear;
    assign resolve_entry = ctrl[resolve_tag];
    assign resolve_ok    = resolve && resolve_entry.valid && !resolve_entry.resolved && !clear;

    assign head_ready  = ctrl[head].valid && ctrl[head].resolved;
    assign head_addr   = addr_mem[head];
    assign head_alt    = alt_mem[head];
    assign head_pred   = ctrl[head].pred_taken;
    assign head_actual = ctrl[head].actual_taken;

    always_comb begin
        count_next = count;
        if (alloc_ok && !pop) begin
            count_next = count + COUNT_ONE;
        end else if (!alloc_ok && pop) begin
            count_next = count - COUNT_ONE;
        end
    end

    // Control state. Alloc/resolve/pop never touch the same entry in one
    // cycle: alloc targets an invalid slot (tail != head unless full, and a
    // full tracker drops the alloc), resolve only hits valid unresolved slots,
    // and pop only hits the resolved head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctrl[i] <= '0;
            end
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctrl[i].valid    <= 1'b0;
                ctrl[i].resolved <= 1'b0;
            end
        end else begin
            if (alloc_ok) begin
                ctrl[tail] <= '{valid: 1'b1, resolved: 1'b0,
                                pred_taken: alloc_pred, actual_taken: 1'b0};
                tail       <= tail + PTR_ONE;
            end
            if (resolve_ok) begin
                ctrl[resolve_tag].resolved     <= 1'b1;
                ctrl[resolve_tag].actual_taken <= resolve_taken;
            end
            if (pop) begin
                ctrl[head].valid    <= 1'b0;
                ctrl[head].resolved <= 1'b0;
                head                <= head + PTR_ONE;
            end
            count <= count_next;
        end
    end

    // Address payload is only meaningful while the matching valid bit is set,
    // so it carries no reset.
    always_ff @(posedge clk) begin
        if (alloc_ok) begin
            addr_mem[tail] <= alloc_addr;
            alt_mem[tail]  <= alloc_alt;
        end
    end

endmodule

// File: rtl/branch_tracker.sv
// -----------------------------------------------------------------------------
// branch_tracker
//
// Tracks conditional branches from fetch/issue to commit. Branches are
// allocated in program order, resolved out of order by the ALU and retired
// in order, one per cycle. Retirement drives the predictor update interface;
// a mispredicted retirement also raises a one-cycle flush with the correct PC
// and empties the tracker.
//
// Ports:
//   clockIn            clock, rising edge
//   resetIn            asynchronous active-low reset
//   readyIn            global enable; 0 freezes all state (strobes drop to 0)
//   allocValid/allocAddr/allocPredTaken/allocAltPC   new branch
//   allocTag           tag given to this cycle's alloc (tail pointer)
//   full, empty        occupancy flags
//   resolveValid/resolveTag/resolveTaken             ALU resolution
//   updateValid/updateInstr/taken                    registered predictor update
//   flushOut/flushPC   registered mispredict flush and redirect target
//   branchCount        retired branches (wraps)
//   mispredictCount    retired mispredicted branches (wraps)
// -----------------------------------------------------------------------------
module branch_tracker
    import branch_tracker_pkg::*;
#(
    parameter int DEPTH_WIDTH = BT_DEPTH_WIDTH,
    parameter int ADDR_WIDTH  = BT_ADDR_WIDTH
) (
    input  logic                    clockIn,
    input  logic                    resetIn,
    input  logic                    readyIn,
    input  logic                    allocValid,
    input  logic [ADDR_WIDTH-1:0]   allocAddr,
    input  logic                    allocPredTaken,
    input  logic [ADDR_WIDTH-1:0]   allocAltPC,
    output logic [DEPTH_WIDTH-1:0]  allocTag,
    output logic                    full,
    output logic                    empty,
    input  logic                    resolveValid,
    input  logic [DEPTH_WIDTH-1:0]  resolveTag,
    input  logic                    resolveTaken,
    output logic                    updateValid,
    output logic [ADDR_WIDTH-1:0]   updateInstr,
    output logic                    taken,
    output logic                    flushOut,
    output logic [ADDR_WIDTH-1:0]   flushPC,
    output logic [BT_CNT_WIDTH-1:0] branchCount,
    output logic [BT_CNT_WIDTH-1:0] mispredictCount
);

    localparam logic [BT_CNT_WIDTH-1:0] CNT_ONE = BT_CNT_WIDTH'(1);

    logic                  head_ready;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [ADDR_WIDTH-1:0] head_alt;
    logic                  head_pred;
    logic                  head_actual;
    logic                  retire;
    logic                  mispredict;

    // Retirement looks only at registered entry state, so a resolve landing
    // at one edge retires at the following edge at the earliest.
    assign retire     = readyIn && head_ready;
    assign mispredict = retire && is_mispredict(head_pred, head_actual);

    branch_tracker_fifo #(
        .DEPTH_WIDTH (DEPTH_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_fifo (
        .clk           (clockIn),
        .rst_n         (resetIn),
        .alloc         (readyIn && allocValid),
        .alloc_addr    (allocAddr),
        .alloc_pred    (allocPredTaken),
        .alloc_alt     (allocAltPC),
        .resolve       (readyIn && resolveValid),
        .resolve_tag   (resolveTag),
        .resolve_taken (resolveTaken),
        .pop           (retire),
        .clear         (mispredict),
        .tail_tag      (allocTag),
        .full          (full),
        .empty         (empty),
        .head_ready    (head_ready),
        .head_addr     (head_addr),
        .head_alt      (head_alt),
        .head_pred     (head_pred),
        .head_actual   (head_actual)
    );

    // Update/flush outputs and performance counters. The payload outputs hold
    // their last value between strobes.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            updateValid     <= 1'b0;
            updateInstr     <= '0;
            taken           <= 1'b0;
            flushOut        <= 1'b0;
            flushPC         <= '0;
            branchCount     <= '0;
            mispredictCount <= '0;
        end else if (!readyIn) begin
            updateValid <= 1'b0;
            flushOut    <= 1'b0;
        end else begin
            updateValid <= retire;
            flushOut    <= mispredict;
            if (retire) begin
                updateInstr <= head_addr;
                taken       <= head_actual;
                branchCount <= branchCount + CNT_ONE;
            end
            if (mispredict) begin
                flushPC         <= head_alt;
                mispredictCount <= mispredictCount + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_branch_tracker.sv
// -----------------------------------------------------------------------------
// tb_branch_tracker
//
// Scenario bench for branch_tracker. Expected predictor updates are queued
// when the resolving stimulus is driven and popped by a monitor whenever the
// DUT raises updateValid; each scenario task also checks its own outputs.
// -----------------------------------------------------------------------------
module tb_branch_tracker;

    logic        clockIn;
    logic        resetIn;
    logic        readyIn;
    logic        allocValid;
    logic [31:0] allocAddr;
    logic        allocPredTaken;
    logic [31:0] allocAltPC;
    logic [2:0]  allocTag;
    logic        full;
    logic        empty;
    logic        resolveValid;
    logic [2:0]  resolveTag;
    logic        resolveTaken;
    logic        updateValid;
    logic [31:0] updateInstr;
    logic        taken;
    logic        flushOut;
    logic [31:0] flushPC;
    logic [31:0] branchCount;
    logic [31:0] mispredictCount;

    branch_tracker #(
        .DEPTH_WIDTH (3),
        .ADDR_WIDTH  (32)
    ) dut (
        .clockIn         (clockIn),
        .resetIn         (resetIn),
        .readyIn         (readyIn),
        .allocValid      (allocValid),
        .allocAddr       (allocAddr),
        .allocPredTaken  (allocPredTaken),
        .allocAltPC      (allocAltPC),
        .allocTag        (allocTag),
        .full            (full),
        .empty           (empty),
        .resolveValid    (resolveValid),
        .resolveTag      (resolveTag),
        .resolveTaken    (resolveTaken),
        .updateValid     (updateValid),
        .updateInstr     (updateInstr),
        .taken           (taken),
        .flushOut        (flushOut),
        .flushPC         (flushPC),
        .branchCount     (branchCount),
        .mispredictCount (mispredictCount)
    );

    typedef struct {
        logic [31:0] addr;
        logic        tk;
        logic        fl;
        logic [31:0] pc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         errors = 0;
    int         checks = 0;
    logic [2:0] m_tail;

    initial clockIn = 1'b0;
    always #5 clockIn = ~clockIn;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every update strobe must match the oldest expected
    // retirement; a flush is only legal together with an update.
    always @(negedge clockIn) begin
        if (resetIn) begin
            if (updateValid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_update: got instr=%h taken=%b flush=%b, required no update",
                             updateInstr, taken, flushOut);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (updateInstr !== mon_e.addr || taken !== mon_e.tk || flushOut !== mon_e.fl ||
                        (mon_e.fl && flushPC !== mon_e.pc)) begin
                        errors++;
                        $display("FAIL update_scoreboard: got instr=%h taken=%b flush=%b pc=%h, required instr=%h taken=%b flush=%b pc=%h",
                                 updateInstr, taken, flushOut, flushPC, mon_e.addr, mon_e.tk, mon_e.fl, mon_e.pc);
                    end
                end
            end else if (flushOut) begin
                checks++;
                errors++;
                $display("FAIL flush_without_update: got flushOut=1, required 0");
            end
        end
    end

    task automatic tick();
        @(posedge clockIn);
        #1;
    endtask

    task automatic do_alloc(input logic [31:0] addr, input logic pred, input logic [31:0] alt);
        allocValid     = 1'b1;
        allocAddr      = addr;
        allocPredTaken = pred;
        allocAltPC     = alt;
        tick();
        allocValid = 1'b0;
        m_tail     = m_tail + 3'd1;
    endtask

    task automatic do_resolve(input logic [2:0] tag, input logic tk);
        resolveValid = 1'b1;
        resolveTag   = tag;
        resolveTaken = tk;
        tick();
        resolveValid = 1'b0;
    endtask

    task automatic test_reset();
        resetIn        = 1'b0;
        readyIn        = 1'b1;
        allocValid     = 1'b0;
        allocAddr      = '0;
        allocPredTaken = 1'b0;
        allocAltPC     = '0;
        resolveValid   = 1'b0;
        resolveTag     = '0;
        resolveTaken   = 1'b0;
        m_tail         = '0;
        repeat (2) @(posedge clockIn);
        #1;
        resetIn = 1'b1;
        tick();
        checks++;
        if (updateValid !== 1'b0 || flushOut !== 1'b0 || taken !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: got upd=%b flush=%b taken=%b, required 0 0 0", updateValid, flushOut, taken);
        end
        checks++;
        if (updateInstr !== 32'h0 || flushPC !== 32'h0) begin
            errors++;
            $display("FAIL reset_payload: got instr=%h pc=%h, required 0 0", updateInstr, flushPC);
        end
        checks++;
        if (branchCount !== 32'd0 || mispredictCount !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d %0d, required 0 0", branchCount, mispredictCount);
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || allocTag !== 3'd0) begin
            errors++;
            $display("FAIL reset_occupancy: got empty=%b full=%b tag=%0d, required 1 0 0", empty, full, allocTag);
        end
    endtask

    task automatic test_basic_retire();
        checks++;
        if (allocTag !== m_tail) begin
            errors++;
            $display("FAIL basic_tag: got %0d, required %0d", allocTag, m_tail);
        end
        do_alloc(32'h1000, 1'b1, 32'h1004);
        exp_q.push_back('{32'h1000, 1'b1, 1'b0, 32'h0});
        do_resolve(3'd0, 1'b1);
        tick();
        checks++;
        if (updateValid !== 1'b1 || updateInstr !== 32'h1000 || taken !== 1'b1 || flushOut !== 1'b0) begin
            errors++;
            $display("FAIL basic_update: got upd=%b instr=%h taken=%b flush=%b, required 1 1000 1 0",
                     updateValid, updateInstr, taken, flushOut);
        end
        checks++;
        if (branchCount !== 32'd1 || empty !== 1'b1) begin
            errors++;
            $display("FAIL basic_count: got count=%0d empty=%b, required 1 1", branchCount, empty);
        end
    endtask

    task automatic test_out_of_order();
        logic [2:0] t0;
        t0 = m_tail;
        do_alloc(32'h2000, 1'b1, 32'h2004);
        do_alloc(32'h2010, 1'b1, 32'h2014);
        do_resolve(t0 + 3'd1, 1'b1);
        repeat (3) tick();
        checks++;
        if (updateValid !== 1'b0 || branchCount !== 32'd1) begin
            errors++;
            $display("FAIL ooo_blocked: got upd=%b count=%0d, required 0 1", updateValid, branchCount);
        end
        exp_q.push_back('{32'h2000, 1'b1, 1'b0, 32'h0});
        exp_q.push_back('{32'h2010, 1'b1, 1'b0, 32'h0});
        do_resolve(t0, 1'b1);
        tick();
        checks++;
        if (updateValid !== 1'b1 || updateInstr !== 32'h2000) begin
            errors++;
            $display("FAIL ooo_first: got upd=%b instr=%h, required 1 2000", updateValid, updateInstr);
        end
        tick();
        checks++;
        if (updateValid !== 1'b1 || updateInstr !== 32'h2010) begin
            errors++;
            $display("FAIL ooo_second: got upd=%b instr=%h, required 1 2010", updateValid, updateInstr);
        end
        tick();
        checks++;
        if (updateValid !== 1'b0 || branchCount !== 32'd3 || empty !== 1'b1) begin
            errors++;
            $display("FAIL ooo_done: got upd=%b count=%0d empty=%b, required 0 3 1", updateValid, branchCount, empty);
        end
    endtask

    task automatic test_mispredict();
        logic [2:0] t0;
        t0 = m_tail;
        do_alloc(32'h3000, 1'b0, 32'h3100);
        do_alloc(32'h3004, 1'b1, 32'h3008);
        exp_q.push_back('{32'h3000, 1'b1, 1'b1, 32'h3100});
        do_resolve(t0, 1'b1);
        // An alloc presented on the flushing edge must be discarded.
        allocValid     = 1'b1;
        allocAddr      = 32'h3FFF;
        allocPredTaken = 1'b1;
        allocAltPC     = 32'h3FF0;
        tick();
        allocValid = 1'b0;
        m_tail     = 3'd0;
        checks++;
        if (updateValid !== 1'b1 || flushOut !== 1'b1 || flushPC !== 32'h3100) begin
            errors++;
            $display("FAIL mp_flush: got upd=%b flush=%b pc=%h, required 1 1 3100", updateValid, flushOut, flushPC);
        end
        checks++;
        if (mispredictCount !== 32'd1 || branchCount !== 32'd4) begin
            errors++;
            $display("FAIL mp_counts: got mp=%0d br=%0d, required 1 4", mispredictCount, branchCount);
        end
        checks++;
        if (empty !== 1'b1 || allocTag !== 3'd0) begin
            errors++;
            $display("FAIL mp_empty: got empty=%b tag=%0d, required 1 0", empty, allocTag);
        end
        do_resolve(t0 + 3'd1, 1'b1);
        checks++;
        if (flushOut !== 1'b0 || updateValid !== 1'b0) begin
            errors++;
            $display("FAIL mp_pulse: got flush=%b upd=%b, required 0 0", flushOut, updateValid);
        end
        repeat (3) tick();
        checks++;
        if (empty !== 1'b1 || branchCount !== 32'd4) begin
            errors++;
            $display("FAIL mp_stale: got empty=%b count=%0d, required 1 4", empty, branchCount);
        end
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (allocTag !== m_tail) begin
                errors++;
                $display("FAIL full_tag%0d: got %0d, required %0d", i, allocTag, m_tail);
            end
            do_alloc(32'h4000 + 32'(4 * i), 1'b1, 32'h4800 + 32'(4 * i));
        end
        checks++;
        if (full !== 1'b1 || empty !== 1'b0 || allocTag !== 3'd0) begin
            errors++;
            $display("FAIL full_flag: got full=%b empty=%b tag=%0d, required 1 0 0", full, empty, allocTag);
        end
        allocValid = 1'b1;
        allocAddr  = 32'h4FFF;
        tick();
        allocValid = 1'b0;
        checks++;
        if (full !== 1'b1 || allocTag !== 3'd0) begin
            errors++;
            $display("FAIL full_drop: got full=%b tag=%0d, required 1 0", full, allocTag);
        end
        exp_q.push_back('{32'h4000, 1'b1, 1'b0, 32'h0});
        do_resolve(3'd0, 1'b1);
        // Alloc while full on the retiring edge is still dropped.
        allocValid = 1'b1;
        allocAddr  = 32'h4EEE;
        tick();
        allocValid = 1'b0;
        checks++;
        if (updateValid !== 1'b1 || updateInstr !== 32'h4000 || full !== 1'b0 || allocTag !== 3'd0) begin
            errors++;
            $display("FAIL full_pop_drop: got upd=%b instr=%h full=%b tag=%0d, required 1 4000 0 0",
                     updateValid, updateInstr, full, allocTag);
        end
        do_alloc(32'h4020, 1'b1, 32'h4820);
        checks++;
        if (full !== 1'b1 || allocTag !== 3'd1) begin
            errors++;
            $display("FAIL full_wrap: got full=%b tag=%0d, required 1 1", full, allocTag);
        end
        for (int i = 1; i < 8; i++) exp_q.push_back('{32'h4000 + 32'(4 * i), 1'b1, 1'b0, 32'h0});
        exp_q.push_back('{32'h4020, 1'b1, 1'b0, 32'h0});
        do_resolve(3'd0, 1'b1);
        for (int t = 7; t >= 1; t--) do_resolve(3'(t), 1'b1);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_drain: got %0d pending updates, required 0", exp_q.size());
        end
        checks++;
        if (branchCount !== 32'd13 || empty !== 1'b1) begin
            errors++;
            $display("FAIL full_count: got count=%0d empty=%b, required 13 1", branchCount, empty);
        end
    endtask

    task automatic test_ready_hold();
        logic [2:0] t0;
        t0 = m_tail;
        do_alloc(32'h5000, 1'b0, 32'h5100);
        exp_q.push_back('{32'h5000, 1'b0, 1'b0, 32'h0});
        do_resolve(t0, 1'b0);
        readyIn        = 1'b0;
        allocValid     = 1'b1;
        allocAddr      = 32'h5555;
        allocPredTaken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (updateValid !== 1'b0 || branchCount !== 32'd13 || allocTag !== t0 + 3'd1) begin
                errors++;
                $display("FAIL ready_freeze%0d: got upd=%b count=%0d tag=%0d, required 0 13 %0d",
                         i, updateValid, branchCount, allocTag, t0 + 3'd1);
            end
        end
        allocValid = 1'b0;
        readyIn    = 1'b1;
        tick();
        checks++;
        if (updateValid !== 1'b1 || updateInstr !== 32'h5000 || taken !== 1'b0 || flushOut !== 1'b0) begin
            errors++;
            $display("FAIL ready_resume: got upd=%b instr=%h taken=%b flush=%b, required 1 5000 0 0",
                     updateValid, updateInstr, taken, flushOut);
        end
        tick();
        checks++;
        if (empty !== 1'b1 || allocTag !== t0 + 3'd1 || branchCount !== 32'd14) begin
            errors++;
            $display("FAIL ready_after: got empty=%b tag=%0d count=%0d, required 1 %0d 14",
                     empty, allocTag, branchCount, t0 + 3'd1);
        end
    endtask

    task automatic test_async_reset();
        logic [2:0] t0;
        t0 = m_tail;
        for (int i = 0; i < 4; i++) do_alloc(32'h6000 + 32'(4 * i), 1'b1, 32'h6800 + 32'(4 * i));
        exp_q.push_back('{32'h6000, 1'b1, 1'b0, 32'h0});
        do_resolve(t0, 1'b1);
        tick();
        @(negedge clockIn);
        #1;
        checks++;
        if (updateValid !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre: got upd=%b, required 1", updateValid);
        end
        resetIn = 1'b0;
        #1;
        checks++;
        if (updateValid !== 1'b0 || flushOut !== 1'b0 || taken !== 1'b0 ||
            updateInstr !== 32'h0 || flushPC !== 32'h0) begin
            errors++;
            $display("FAIL arst_outputs: got upd=%b flush=%b taken=%b instr=%h pc=%h, required all 0",
                     updateValid, flushOut, taken, updateInstr, flushPC);
        end
        checks++;
        if (branchCount !== 32'd0 || mispredictCount !== 32'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL arst_state: got br=%0d mp=%0d empty=%b, required 0 0 1",
                     branchCount, mispredictCount, empty);
        end
        @(posedge clockIn);
        #1;
        resetIn = 1'b1;
        m_tail  = 3'd0;
        tick();
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || allocTag !== 3'd0) begin
            errors++;
            $display("FAIL arst_release: got empty=%b full=%b tag=%0d, required 1 0 0", empty, full, allocTag);
        end
        for (int i = 1; i < 4; i++) do_resolve(t0 + 3'(i), 1'b1);
        repeat (3) tick();
        checks++;
        if (branchCount !== 32'd0 || updateValid !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL arst_lost: got count=%0d upd=%b empty=%b, required 0 0 1",
                     branchCount, updateValid, empty);
        end
    endtask

    initial begin
        test_reset();
        test_basic_retire();
        test_out_of_order();
        test_mispredict();
        test_full_wrap();
        test_ready_hold();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d pending updates, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
